// File: rtl/pipelined_control.sv
// pipelined_control: ID decode, hazard/flush/IRQ steering and EX/MEM/WB control pipeline
module pipelined_control #(
    parameter int NUM_IRQ = 4,
    parameter int REG_W   = 5,
    parameter int IRQ_REG = 26
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        id_instr,
    input  logic               id_valid,
    input  logic               id_kernel,
    input  logic [NUM_IRQ-1:0] irq_src,
    input  logic [NUM_IRQ-1:0] irq_mask,
    input  logic               ex_branch_taken,
    output logic               stall,
    output logic               flush_ifid,
    output logic [2:0]         pc_src,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [5:0]         ex_alu_fun,
    output logic               ex_alu_src1,
    output logic               ex_alu_src2,
    output logic               ex_sign,
    output logic               ex_ext_op,
    output logic               ex_lu_op,
    output logic               ex_is_branch,
    output logic [REG_W-1:0]   ex_dst,
    output logic               ex_reg_wr,
    output logic               ex_mem_rd,
    output logic               mem_mem_wr,
    output logic               mem_mem_rd,
    output logic               mem_reg_wr,
    output logic [REG_W-1:0]   mem_dst,
    output logic               wb_reg_wr,
    output logic [1:0]         wb_mem_to_reg,
    output logic [REG_W-1:0]   wb_dst
);
    localparam logic [5:0] ALU_ADD = 6'b000000, ALU_SUB = 6'b000001, ALU_AND = 6'b011000,
                           ALU_OR  = 6'b011110, ALU_XOR = 6'b010110, ALU_NOR = 6'b010001,
                           ALU_SLL = 6'b100000, ALU_SRL = 6'b100001, ALU_SRA = 6'b100011,
                           ALU_EQ  = 6'b110011, ALU_NEQ = 6'b110001, ALU_LT  = 6'b110101,
                           ALU_LEZ = 6'b111101, ALU_GEZ = 6'b111001, ALU_GTZ = 6'b111111;
    localparam logic [REG_W-1:0] RA_DST  = REG_W'(31);
    localparam logic [REG_W-1:0] IRQ_DST = REG_W'(IRQ_REG);

    typedef struct packed {
        logic [5:0]       alu_fun;
        logic             alu_src1;
        logic             alu_src2;
        logic             sign;
        logic             ext_op;
        logic             lu_op;
        logic             is_branch;
        logic             reg_wr;
        logic             mem_rd;
        logic             mem_wr;
        logic [1:0]       mem_to_reg;
        logic [REG_W-1:0] dst;
    } ctrl_t;

    logic [5:0]         op, funct;
    logic [4:0]         shamt;
    logic [REG_W-1:0]   rs, rt, rd;
    ctrl_t              d, nxt, idex;
    logic               legal, use_rs, use_rt, is_j, is_jr, shift;
    logic               br_flush, hazard, take_irq, take_exc, take_jmp;
    logic [NUM_IRQ-1:0] irq_q, pending, elig;
    logic [1:0]         mem_m2r;

    assign op    = id_instr[31:26];
    assign rs    = REG_W'(id_instr[25:21]);
    assign rt    = REG_W'(id_instr[20:16]);
    assign rd    = REG_W'(id_instr[15:11]);
    assign shamt = id_instr[10:6];
    assign funct = id_instr[5:0];

    // Decode the ID instruction into its control bundle, operand usage and legality
    always_comb begin
        d        = '0;
        d.sign   = 1'b1;
        d.ext_op = 1'b1;
        legal    = 1'b1;
        use_rs   = 1'b1;
        use_rt   = 1'b0;
        is_j     = 1'b0;
        is_jr    = 1'b0;
        shift    = 1'b0;
        case (op)
            6'h00: begin
                d.dst    = rd;
                d.reg_wr = 1'b1;
                use_rt   = 1'b1;
                case (funct)
                    6'h20: d.alu_fun = ALU_ADD;
                    6'h21: begin d.alu_fun = ALU_ADD; d.sign = 1'b0; end
                    6'h22: d.alu_fun = ALU_SUB;
                    6'h23: begin d.alu_fun = ALU_SUB; d.sign = 1'b0; end
                    6'h24: d.alu_fun = ALU_AND;
                    6'h25: d.alu_fun = ALU_OR;
                    6'h26: d.alu_fun = ALU_XOR;
                    6'h27: d.alu_fun = ALU_NOR;
                    6'h00: begin d.alu_fun = ALU_SLL; d.alu_src1 = 1'b1; use_rs = 1'b0; shift = 1'b1; end
                    6'h02: begin d.alu_fun = ALU_SRL; d.alu_src1 = 1'b1; use_rs = 1'b0; shift = 1'b1; end
                    6'h03: begin d.alu_fun = ALU_SRA; d.alu_src1 = 1'b1; use_rs = 1'b0; shift = 1'b1; end
                    6'h2A: d.alu_fun = ALU_LT;
                    6'h2B: begin d.alu_fun = ALU_LT; d.sign = 1'b0; end
                    6'h08: begin d.dst = '0; d.reg_wr = 1'b0; use_rt = 1'b0; is_jr = 1'b1; end
                    6'h09: begin d.mem_to_reg = 2'b10; use_rt = 1'b0; is_jr = 1'b1; end
                    default: legal = 1'b0;
                endcase
                if (!shift && shamt != 5'd0) legal = 1'b0;
            end
            6'h23: begin d.dst = rt; d.reg_wr = 1'b1; d.mem_rd = 1'b1; d.alu_src2 = 1'b1; d.mem_to_reg = 2'b01; end
            6'h2B: begin d.mem_wr = 1'b1; d.alu_src2 = 1'b1; use_rt = 1'b1; end
            6'h0F: begin d.dst = rt; d.reg_wr = 1'b1; d.alu_src2 = 1'b1; d.lu_op = 1'b1; use_rs = 1'b0; end
            6'h08: begin d.dst = rt; d.reg_wr = 1'b1; d.alu_src2 = 1'b1; end
            6'h09: begin d.dst = rt; d.reg_wr = 1'b1; d.alu_src2 = 1'b1; d.sign = 1'b0; end
            6'h0C: begin d.dst = rt; d.reg_wr = 1'b1; d.alu_src2 = 1'b1; d.alu_fun = ALU_AND; d.ext_op = 1'b0; end
            6'h0A: begin d.dst = rt; d.reg_wr = 1'b1; d.alu_src2 = 1'b1; d.alu_fun = ALU_LT; end
            6'h0B: begin d.dst = rt; d.reg_wr = 1'b1; d.alu_src2 = 1'b1; d.alu_fun = ALU_LT; d.sign = 1'b0; d.ext_op = 1'b0; end
            6'h02: begin is_j = 1'b1; use_rs = 1'b0; end
            6'h03: begin is_j = 1'b1; use_rs = 1'b0; d.dst = RA_DST; d.reg_wr = 1'b1; d.mem_to_reg = 2'b10; end
            6'h04: begin d.is_branch = 1'b1; d.alu_fun = ALU_EQ; use_rt = 1'b1; end
            6'h05: begin d.is_branch = 1'b1; d.alu_fun = ALU_NEQ; use_rt = 1'b1; end
            6'h06: begin d.is_branch = 1'b1; d.alu_fun = ALU_LEZ; end
            6'h07: begin d.is_branch = 1'b1; d.alu_fun = ALU_GTZ; end
            6'h01: begin d.is_branch = 1'b1; d.alu_fun = ALU_GEZ; legal = (id_instr[20:16] == 5'd1); end
            default: legal = 1'b0;
        endcase
        if (d.dst == '0) d.reg_wr = 1'b0;
    end

    assign br_flush = idex.is_branch & ex_branch_taken;
    assign hazard   = id_valid & legal & ~br_flush &
                      ((idex.mem_rd & (idex.dst != '0) & ((use_rs & idex.dst == rs) | (use_rt & idex.dst == rt))) |
                       (is_jr & idex.reg_wr & idex.dst == rs));
    assign elig     = pending & irq_mask;
    assign take_irq = id_valid & ~id_kernel & ~br_flush & ~hazard & (|elig);
    assign take_exc = id_valid & ~legal & ~br_flush & ~take_irq;
    assign take_jmp = id_valid & legal & ~br_flush & ~hazard & ~take_irq & (is_j | is_jr);

    assign stall      = hazard;
    assign irq_ack    = take_irq ? (elig & (~elig + NUM_IRQ'(1))) : '0;
    assign flush_ifid = br_flush | take_irq | take_exc | take_jmp;
    assign pc_src     = br_flush ? 3'b001 : take_irq ? 3'b100 : take_exc ? 3'b101 :
                        take_jmp ? (is_j ? 3'b010 : 3'b011) : 3'b000;

    // Select what enters ID/EX: trap bundle, bubble, or the decoded instruction
    always_comb begin
        nxt = d;
        if (take_irq | take_exc) begin
            nxt            = '0;
            nxt.reg_wr     = 1'b1;
            nxt.dst        = IRQ_DST;
            nxt.mem_to_reg = 2'b10;
        end
        if (!id_valid || br_flush || hazard) nxt = '0;
    end

    // Latch rising edges of each request; an ack clears unless a fresh edge arrives together
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_q   <= '0;
            pending <= '0;
        end else begin
            irq_q   <= irq_src;
            pending <= (pending & ~irq_ack) | (irq_src & ~irq_q);
        end
    end

    // ID/EX register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) idex <= '0;
        else        idex <= nxt;
    end

    // EX/MEM register always advances, even during a stall
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_mem_wr <= 1'b0;
            mem_mem_rd <= 1'b0;
            mem_reg_wr <= 1'b0;
            mem_dst    <= '0;
            mem_m2r    <= 2'b00;
        end else begin
            mem_mem_wr <= idex.mem_wr;
            mem_mem_rd <= idex.mem_rd;
            mem_reg_wr <= idex.reg_wr;
            mem_dst    <= idex.dst;
            mem_m2r    <= idex.mem_to_reg;
        end
    end

    // MEM/WB register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wb_reg_wr     <= 1'b0;
            wb_mem_to_reg <= 2'b00;
            wb_dst        <= '0;
        end else begin
            wb_reg_wr     <= mem_reg_wr;
            wb_mem_to_reg <= mem_m2r;
            wb_dst        <= mem_dst;
        end
    end

    assign ex_alu_fun   = idex.alu_fun;
    assign ex_alu_src1  = idex.alu_src1;
    assign ex_alu_src2  = idex.alu_src2;
    assign ex_sign      = idex.sign;
    assign ex_ext_op    = idex.ext_op;
    assign ex_lu_op     = idex.lu_op;
    assign ex_is_branch = idex.is_branch;
    assign ex_dst       = idex.dst;
    assign ex_reg_wr    = idex.reg_wr;
    assign ex_mem_rd    = idex.mem_rd;
endmodule

// File: tb/tb_pipelined_control.sv
// tb_pipelined_control: scoreboard bench for decode, hazards, flushes and interrupts
module tb_pipelined_control;
    typedef struct packed {
        logic [5:0] fun;
        logic [4:0] dst;
        logic       wr;
        logic       mrd;
        logic       mwr;
        logic       br;
        logic [1:0] m2r;
    } exp_t;

    logic        clk = 1'b0, reset = 1'b0;
    logic [31:0] id_instr = '0;
    logic        id_valid = 1'b0, id_kernel = 1'b0, ex_branch_taken = 1'b0;
    logic [3:0]  irq_src = '0, irq_mask = '0;
    logic        stall, flush_ifid;
    logic [2:0]  pc_src;
    logic [3:0]  irq_ack;
    logic [5:0]  ex_alu_fun;
    logic        ex_alu_src1, ex_alu_src2, ex_sign, ex_ext_op, ex_lu_op, ex_is_branch;
    logic [4:0]  ex_dst, mem_dst, wb_dst;
    logic        ex_reg_wr, ex_mem_rd, mem_mem_wr, mem_mem_rd, mem_reg_wr, wb_reg_wr;
    logic [1:0]  wb_mem_to_reg;

    int   compared = 0, mismatched = 0;
    bit   sb_on = 1'b0;
    exp_t exq[$];
    exp_t exp_ex, exp_mem, exp_wb, e;

    localparam logic [31:0] ADD3 = 32'h00221820, LW4 = 32'h8CA40000, ADD641 = 32'h00813020,
                            ADD671 = 32'h00E13020, BEQ = 32'h10220004, ADD0 = 32'h00220020,
                            BADOP = 32'hFC000000, ADDSH = 32'h00221860, JMP = 32'h08000010,
                            JAL = 32'h0C000010, JR31 = 32'h03E00008;

    function automatic exp_t mk(input logic [5:0] f, input logic [4:0] dst, input logic wr, mrd, mwr, br,
                                input logic [1:0] m2r);
        exp_t r;
        r.fun = f; r.dst = dst; r.wr = wr; r.mrd = mrd; r.mwr = mwr; r.br = br; r.m2r = m2r;
        return r;
    endfunction

    localparam exp_t BUB  = '0;
    localparam exp_t TRAP = '{fun: 6'd0, dst: 5'd26, wr: 1'b1, mrd: 1'b0, mwr: 1'b0, br: 1'b0, m2r: 2'b10};
    localparam exp_t EADD3 = '{fun: 6'd0, dst: 5'd3, wr: 1'b1, mrd: 1'b0, mwr: 1'b0, br: 1'b0, m2r: 2'b00};
    localparam exp_t EADD6 = '{fun: 6'd0, dst: 5'd6, wr: 1'b1, mrd: 1'b0, mwr: 1'b0, br: 1'b0, m2r: 2'b00};
    localparam exp_t ELW4  = '{fun: 6'd0, dst: 5'd4, wr: 1'b1, mrd: 1'b1, mwr: 1'b0, br: 1'b0, m2r: 2'b01};

    pipelined_control dut (
        .clk(clk), .reset(reset), .id_instr(id_instr), .id_valid(id_valid), .id_kernel(id_kernel),
        .irq_src(irq_src), .irq_mask(irq_mask), .ex_branch_taken(ex_branch_taken),
        .stall(stall), .flush_ifid(flush_ifid), .pc_src(pc_src), .irq_ack(irq_ack),
        .ex_alu_fun(ex_alu_fun), .ex_alu_src1(ex_alu_src1), .ex_alu_src2(ex_alu_src2),
        .ex_sign(ex_sign), .ex_ext_op(ex_ext_op), .ex_lu_op(ex_lu_op), .ex_is_branch(ex_is_branch),
        .ex_dst(ex_dst), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd),
        .mem_mem_wr(mem_mem_wr), .mem_mem_rd(mem_mem_rd), .mem_reg_wr(mem_reg_wr), .mem_dst(mem_dst),
        .wb_reg_wr(wb_reg_wr), .wb_mem_to_reg(wb_mem_to_reg), .wb_dst(wb_dst)
    );

    always #5 clk = ~clk;

    // Scoreboard: each posedge consumes the bundle pushed for the previous ID cycle
    always @(posedge clk) begin
        #1;
        if (sb_on) begin
            exp_wb  = exp_mem;
            exp_mem = exp_ex;
            if (exq.size() == 0) begin
                mismatched++;
                $display("FAIL sb_underflow t=%0t no expected entry queued", $time);
                exp_ex = BUB;
            end else exp_ex = exq.pop_front();
            compared++;
            if ({ex_alu_fun, ex_dst, ex_reg_wr, ex_mem_rd, ex_is_branch} !== {exp_ex.fun, exp_ex.dst, exp_ex.wr, exp_ex.mrd, exp_ex.br}) begin
                mismatched++;
                $display("FAIL ex_stage t=%0t got fun=%b dst=%0d wr=%b mrd=%b br=%b want fun=%b dst=%0d wr=%b mrd=%b br=%b",
                         $time, ex_alu_fun, ex_dst, ex_reg_wr, ex_mem_rd, ex_is_branch,
                         exp_ex.fun, exp_ex.dst, exp_ex.wr, exp_ex.mrd, exp_ex.br);
            end
            compared++;
            if ({mem_mem_wr, mem_mem_rd, mem_reg_wr, mem_dst} !== {exp_mem.mwr, exp_mem.mrd, exp_mem.wr, exp_mem.dst}) begin
                mismatched++;
                $display("FAIL mem_stage t=%0t got mwr=%b mrd=%b wr=%b dst=%0d want mwr=%b mrd=%b wr=%b dst=%0d",
                         $time, mem_mem_wr, mem_mem_rd, mem_reg_wr, mem_dst, exp_mem.mwr, exp_mem.mrd, exp_mem.wr, exp_mem.dst);
            end
            compared++;
            if ({wb_reg_wr, wb_mem_to_reg, wb_dst} !== {exp_wb.wr, exp_wb.m2r, exp_wb.dst}) begin
                mismatched++;
                $display("FAIL wb_stage t=%0t got wr=%b m2r=%b dst=%0d want wr=%b m2r=%b dst=%0d",
                         $time, wb_reg_wr, wb_mem_to_reg, wb_dst, exp_wb.wr, exp_wb.m2r, exp_wb.dst);
            end
        end
    end

    task automatic do_reset();
        sb_on = 1'b0;
        reset = 1'b0;
        id_valid = 1'b0; id_instr = '0; id_kernel = 1'b0;
        irq_src = '0; irq_mask = '0; ex_branch_taken = 1'b0;
        repeat (2) @(negedge clk);
        exq.delete();
        exp_ex = BUB; exp_mem = BUB; exp_wb = BUB;
        reset = 1'b1;
        @(posedge clk);
        #2;
        sb_on = 1'b1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic v, input logic k, input exp_t ex);
        @(negedge clk);
        id_instr = ins; id_valid = v; id_kernel = k;
        exq.push_back(ex);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) issue(32'h0, 1'b0, 1'b0, BUB);
    endtask

    task automatic test_reset();
        do_reset();
        issue(LW4, 1'b1, 1'b0, ELW4);
        issue(ADD641, 1'b1, 1'b0, BUB);
        compared++;
        if (stall !== 1'b1) begin
            mismatched++;
            $display("FAIL pre_reset_stall got %b want 1", stall);
        end
        sb_on = 1'b0;
        reset = 1'b0;
        #1;
        compared++;
        if ({stall, flush_ifid, pc_src, irq_ack, ex_alu_fun, ex_dst, ex_reg_wr, ex_mem_rd, mem_reg_wr, mem_mem_rd, mem_mem_wr, wb_reg_wr, wb_dst, wb_mem_to_reg} !== '0) begin
            mismatched++;
            $display("FAIL reset_state got stall=%b flush=%b pc=%b ack=%b fun=%b exdst=%0d exwr=%b exmrd=%b memwr=%b wbwr=%b want all 0",
                     stall, flush_ifid, pc_src, irq_ack, ex_alu_fun, ex_dst, ex_reg_wr, ex_mem_rd, mem_reg_wr, wb_reg_wr);
        end
        do_reset();
    endtask

    task automatic test_alu();
        do_reset();
        issue(ADD3, 1'b1, 1'b0, EADD3);
        compared++;
        if ({stall, flush_ifid, pc_src} !== 5'b0) begin
            mismatched++;
            $display("FAIL add_steer got stall=%b flush=%b pc=%b want 0/0/000", stall, flush_ifid, pc_src);
        end
        idle(3);
    endtask

    task automatic test_back_to_back();
        logic [31:0] ins[5];
        exp_t        ex[5];
        ins = '{32'h00222822, 32'h00031100, 32'h28270005, 32'hACA40008, 32'h20080001};
        ex[0] = mk(6'b000001, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        ex[1] = mk(6'b100000, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        ex[2] = mk(6'b110101, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        ex[3] = mk(6'b000000, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
        ex[4] = mk(6'b000000, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            issue(ins[i], 1'b1, 1'b0, ex[i]);
            compared++;
            if ({stall, flush_ifid, pc_src} !== 5'b0) begin
                mismatched++;
                $display("FAIL b2b_steer[%0d] got stall=%b flush=%b pc=%b want 0/0/000", i, stall, flush_ifid, pc_src);
            end
        end
        idle(3);
    endtask

    task automatic test_load_use();
        do_reset();
        issue(LW4, 1'b1, 1'b0, ELW4);
        issue(ADD641, 1'b1, 1'b0, BUB);
        compared++;
        if ({stall, flush_ifid, pc_src} !== 5'b10000) begin
            mismatched++;
            $display("FAIL load_use_stall got stall=%b flush=%b pc=%b want 1/0/000", stall, flush_ifid, pc_src);
        end
        issue(ADD641, 1'b1, 1'b0, EADD6);
        compared++;
        if (stall !== 1'b0) begin
            mismatched++;
            $display("FAIL load_use_release got stall=%b want 0", stall);
        end
        issue(LW4, 1'b1, 1'b0, ELW4);
        issue(ADD671, 1'b1, 1'b0, EADD6);
        compared++;
        if (stall !== 1'b0) begin
            mismatched++;
            $display("FAIL load_no_dep got stall=%b want 0", stall);
        end
        idle(3);
    endtask

    task automatic test_branch_irq();
        do_reset();
        irq_mask = 4'hF;
        issue(BEQ, 1'b1, 1'b0, mk(6'b110011, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00));
        irq_src = 4'b0001;
        #1;
        compared++;
        if ({pc_src, irq_ack} !== 7'b0) begin
            mismatched++;
            $display("FAIL beq_in_id got pc=%b ack=%b want 000/0000", pc_src, irq_ack);
        end
        issue(ADD3, 1'b1, 1'b0, BUB);
        ex_branch_taken = 1'b1;
        #1;
        compared++;
        if ({pc_src, flush_ifid, irq_ack, stall} !== {3'b001, 1'b1, 4'b0000, 1'b0}) begin
            mismatched++;
            $display("FAIL branch_over_irq got pc=%b flush=%b ack=%b stall=%b want 001/1/0000/0", pc_src, flush_ifid, irq_ack, stall);
        end
        issue(ADD3, 1'b1, 1'b0, TRAP);
        ex_branch_taken = 1'b0;
        #1;
        compared++;
        if ({pc_src, flush_ifid, irq_ack} !== {3'b100, 1'b1, 4'b0001}) begin
            mismatched++;
            $display("FAIL irq_after_branch got pc=%b flush=%b ack=%b want 100/1/0001", pc_src, flush_ifid, irq_ack);
        end
        issue(ADD3, 1'b1, 1'b0, EADD3);
        compared++;
        if ({pc_src, irq_ack} !== 7'b0) begin
            mismatched++;
            $display("FAIL irq_cleared got pc=%b ack=%b want 000/0000", pc_src, irq_ack);
        end
        idle(3);
    endtask

    task automatic test_irq_priority();
        do_reset();
        irq_mask = 4'hF;
        idle(1);
        irq_src = 4'b0110;
        issue(ADD3, 1'b1, 1'b0, TRAP);
        compared++;
        if ({pc_src, irq_ack} !== {3'b100, 4'b0010}) begin
            mismatched++;
            $display("FAIL irq_lowest got pc=%b ack=%b want 100/0010", pc_src, irq_ack);
        end
        issue(ADD3, 1'b1, 1'b0, TRAP);
        compared++;
        if ({pc_src, irq_ack} !== {3'b100, 4'b0100}) begin
            mismatched++;
            $display("FAIL irq_next got pc=%b ack=%b want 100/0100", pc_src, irq_ack);
        end
        issue(ADD3, 1'b1, 1'b0, EADD3);
        compared++;
        if (irq_ack !== 4'b0000) begin
            mismatched++;
            $display("FAIL irq_drained got ack=%b want 0000", irq_ack);
        end
        idle(3);
    endtask

    task automatic test_kernel_mask();
        do_reset();
        irq_mask = 4'hF;
        idle(1);
        irq_src = 4'b0001;
        for (int i = 0; i < 2; i++) begin
            issue(ADD3, 1'b1, 1'b1, EADD3);
            compared++;
            if ({pc_src, irq_ack} !== 7'b0) begin
                mismatched++;
                $display("FAIL kernel_block[%0d] got pc=%b ack=%b want 000/0000", i, pc_src, irq_ack);
            end
        end
        issue(ADD3, 1'b1, 1'b0, TRAP);
        compared++;
        if ({pc_src, irq_ack} !== {3'b100, 4'b0001}) begin
            mismatched++;
            $display("FAIL kernel_exit got pc=%b ack=%b want 100/0001", pc_src, irq_ack);
        end
        idle(1);
        irq_mask = 4'b0111;
        irq_src  = 4'b1001;
        for (int i = 0; i < 5; i++) begin
            issue(ADD3, 1'b1, 1'b0, EADD3);
            compared++;
            if (irq_ack !== 4'b0000) begin
                mismatched++;
                $display("FAIL masked_hold[%0d] got ack=%b want 0000", i, irq_ack);
            end
        end
        issue(ADD3, 1'b1, 1'b0, TRAP);
        irq_mask = 4'hF;
        #1;
        compared++;
        if ({pc_src, irq_ack} !== {3'b100, 4'b1000}) begin
            mismatched++;
            $display("FAIL unmask_take got pc=%b ack=%b want 100/1000", pc_src, irq_ack);
        end
        idle(3);
    endtask

    task automatic test_illegal_jump();
        do_reset();
        issue(BADOP, 1'b1, 1'b0, TRAP);
        compared++;
        if ({pc_src, flush_ifid, irq_ack} !== {3'b101, 1'b1, 4'b0000}) begin
            mismatched++;
            $display("FAIL illegal_op got pc=%b flush=%b ack=%b want 101/1/0000", pc_src, flush_ifid, irq_ack);
        end
        issue(ADD0, 1'b1, 1'b0, BUB);
        compared++;
        if (pc_src !== 3'b000) begin
            mismatched++;
            $display("FAIL add_r0 got pc=%b want 000", pc_src);
        end
        issue(ADDSH, 1'b1, 1'b0, TRAP);
        compared++;
        if (pc_src !== 3'b101) begin
            mismatched++;
            $display("FAIL shamt_illegal got pc=%b want 101", pc_src);
        end
        issue(JMP, 1'b1, 1'b0, BUB);
        compared++;
        if ({pc_src, flush_ifid} !== {3'b010, 1'b1}) begin
            mismatched++;
            $display("FAIL jump got pc=%b flush=%b want 010/1", pc_src, flush_ifid);
        end
        issue(JAL, 1'b1, 1'b0, mk(6'd0, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, 2'b10));
        compared++;
        if ({pc_src, flush_ifid} !== {3'b010, 1'b1}) begin
            mismatched++;
            $display("FAIL jal got pc=%b flush=%b want 010/1", pc_src, flush_ifid);
        end
        issue(JR31, 1'b1, 1'b0, BUB);
        compared++;
        if ({stall, pc_src, flush_ifid} !== {1'b1, 3'b000, 1'b0}) begin
            mismatched++;
            $display("FAIL jr_hazard got stall=%b pc=%b flush=%b want 1/000/0", stall, pc_src, flush_ifid);
        end
        issue(JR31, 1'b1, 1'b0, BUB);
        compared++;
        if ({stall, pc_src, flush_ifid} !== {1'b0, 3'b011, 1'b1}) begin
            mismatched++;
            $display("FAIL jr got stall=%b pc=%b flush=%b want 0/011/1", stall, pc_src, flush_ifid);
        end
        idle(3);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load_use();
        test_branch_irq();
        test_irq_priority();
        test_kernel_mask();
        test_illegal_jump();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1);
    end
endmodule

// File: doc/pipelined_control.md
Name: pipelined_control

Overview:
- Successor of the single-cycle decoder for the 5-stage MIPS core.
- Decodes the ID-stage instruction into the same control encodings and carries the control bundle through ID/EX, EX/MEM and MEM/WB registers.
- Adds load-use stall detection, jump and branch flushing, and a multi-source latched interrupt controller with mask and lowest-index priority.
- Sits between the IF/ID register and the datapath pipeline registers.

Parameters:
- NUM_IRQ, 4, number of interrupt sources (1..8).
- REG_W, 5, register-address width.
- IRQ_REG, 26, register written with the return PC on interrupt or exception ($k0).

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-low reset
- id_instr  in  32  instruction in ID
- id_valid  in  1  ID holds a real instruction (0 = bubble)
- id_kernel  in  1  PC[31] of the ID instruction; 1 = kernel mode, IRQs blocked
- irq_src  in  NUM_IRQ  level interrupt requests
- irq_mask  in  NUM_IRQ  1 = source enabled
- ex_branch_taken  in  1  branch in EX resolved taken (valid only when ex_is_branch)
- stall  out  1  hold PC and IF/ID; insert a bubble into ID/EX
- flush_ifid  out  1  squash IF/ID next edge
- pc_src  out  3  000 PC+4, 001 branch, 010 jump, 011 jr, 100 IRQ, 101 exception
- irq_ack  out  NUM_IRQ  one-hot, one cycle, source serviced
- ex_alu_fun  out  6  ALU function code
- ex_alu_src1, ex_alu_src2, ex_sign, ex_ext_op, ex_lu_op, ex_is_branch  out  1 each
- ex_dst  out  REG_W  resolved destination register
- ex_reg_wr, ex_mem_rd  out  1
- mem_mem_wr, mem_mem_rd, mem_reg_wr  out  1
- mem_dst  out  REG_W
- wb_reg_wr  out  1
- wb_mem_to_reg  out  2  00 ALU, 01 memory, 10 PC+4
- wb_dst  out  REG_W

Behaviour:
- Reset (reset=0, async):
  - All stage registers become a bubble: every write/read enable 0, alu_fun 000000, dst 0.
  - Pending register cleared; stall=0, flush_ifid=0, pc_src=000, irq_ack=0.
- Latency: the ID decode appears on ex_* one cycle later, mem_* two cycles later, wb_* three cycles later. A bubble advances like an instruction with all enables 0.
- Decode table (combinational in ID):
  - Instruction set: lw, sw, lui, addi, addiu, andi, slti, sltiu, j, jal, beq, bne, blez, bgtz, bgez, R-type add, addu, sub, subu, and, or, xor, nor, sll, srl, sra, slt, sltu, jr, jalr.
  - ALU codes: ADD 000000, SUB 000001, AND 011000, OR 011110, XOR 010110, NOR 010001, SLL 100000, SRL 100001, SRA 100011, EQ 110011, NEQ 110001, LT 110101, LEZ 111101, GEZ 111001, GTZ 111111.
  - Destination: I-type → rt; R-type → rd; jal → 31; jalr → rd.
  - Any writing instruction with dst=0 forces reg_wr=0.
  - Unsigned forms: sign=0. sltiu: ext_op=0.
  - Any other encoding, including a nonzero shamt on non-shift R-types, is illegal.
- Priority each cycle, highest first:
  - P1 EX branch taken (ex_is_branch & ex_branch_taken): pc_src=001, flush_ifid=1, ID replaced by a bubble. No stall, IRQ or exception this cycle.
  - P2 load-use: ex_mem_rd & ex_dst≠0 & ex_dst∈{rs, rt used by the ID instruction} → stall=1, bubble into ID/EX, pc_src=000. The same rule applies to jr/jalr when ex_reg_wr & ex_dst==rs.
  - P3 IRQ: any (pending & irq_mask), id_valid=1, id_kernel=0. The lowest index i wins.
    - pc_src=100, flush_ifid=1, irq_ack[i]=1, pending[i] cleared at the edge.
    - ID bundle becomes reg_wr=1, dst=IRQ_REG, mem_to_reg=10. The ID instruction is abandoned and re-executes after return.
  - P4 illegal instruction with id_valid=1: pc_src=101, flush_ifid=1, bundle as in P3, no ack.
  - P5 j/jal: pc_src=010; jr/jalr: pc_src=011; flush_ifid=1 in both cases.
  - P6 otherwise pc_src=000.
- Pending logic:
  - pending[i] is set on a registered rising edge of irq_src[i].
  - Setting is independent of the mask: a masked source stays pending until it is unmasked.
  - Set and clear on the same edge → set wins only for a new rising edge; otherwise clear wins.
- Stall: only ID/EX takes the bubble. EX/MEM and MEM/WB always advance.
- Reset mid-stall or mid-IRQ: everything returns to the reset state and the IRQ is lost.

Test Plan:
- Reset, then add $3,$1,$2 (0x00221820) in ID → next cycle ex_alu_fun=000000, ex_dst=3, ex_reg_wr=1; three cycles later wb_reg_wr=1, wb_dst=3, wb_mem_to_reg=00.
- lw $4,0($5) followed by add $6,$4,$1 → stall=1 for exactly one cycle, ex_reg_wr=0 on the bubble, then add proceeds. The same sequence with add $6,$7,$1 → no stall.
- beq in EX with ex_branch_taken=1 while irq_src[0] is pending → pc_src=001, flush_ifid=1, irq_ack=0. Next cycle → pc_src=100, irq_ack=0001.
- irq_src=0110, irq_mask=1111, id_kernel=0 → irq_ack=0010, ex_dst=26, wb_mem_to_reg=10. Next eligible cycle → irq_ack=0100.
- Same IRQ with id_kernel=1 → no ack and pending held; take it on the first cycle id_kernel=0. A masked source raised then unmasked 5 cycles later → acked.
- Opcode 0x3F in ID → pc_src=101, ex_dst=26, ex_reg_wr=1. add $0,$1,$2 → ex_reg_wr=0.
